latent_reparam: RTL and testbench
=================================

// Module: latent_reparam
// PURPOSE
//   Downstream consumer of the 2x1 encoder output layer. Takes the layer's two
//   biased results as (mu, logvar) and produces one latent sample
//   z = mu + exp(logvar/2) * eps. eps comes from an internal LFSR or from an
//   external test value.
//   Multi-cycle FSM, one sample per start; z feeds the decoder input stage.
// PARAMETERS
//   FRAC   8         fractional bits of every 16-bit signed fixed-point value
//   LOG2E  16'd369   log2(e) in Q(16-FRAC).FRAC (1.4427*256)
//   SEED   16'hACE1  LFSR reset value; must be nonzero
// PORTS
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-low reset
//   start      in   1   request one sample; accepted only in IDLE
//   mu_in      in   16  signed mean (layer result 1)
//   logvar_in  in   16  signed log-variance (layer result 2)
//   eps_sel    in   1   1: use eps_ext, 0: use LFSR-derived eps
//   eps_ext    in   16  signed external eps, Q.FRAC
//   z_out      out  16  signed latent sample, held until next result
//   z_valid    out  1   one-cycle pulse when z_out updates
//   busy       out  1   high while state != IDLE
// BEHAVIOUR
//   Reset (async, rst=0): state=IDLE, z_out=0, z_valid=0, busy=0, lfsr=SEED,
//     all pipeline registers 0. Asserting reset mid-operation aborts the sample,
//     and no z_valid is issued for it.
//   FSM: IDLE -> EXP -> SIG -> MUL -> ADD -> IDLE, one clock edge per state.
//   IDLE & start (edge 1): latch mu_in and logvar_in.
//     Latch eps = eps_sel ? eps_ext : sign-extend(lfsr[8:0]), giving a range of
//     [-1,1) at FRAC=8. Advance the LFSR once; go to EXP.
//   start while busy is ignored and does not advance the LFSR.
//   LFSR: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//   EXP (edge 2): y = logvar>>>1; t = (y*LOG2E)>>>FRAC, computed in 32 bits.
//     Register k = t>>>FRAC (signed floor) and f = t[FRAC-1:0].
//   SIG (edge 3): s = (1<<FRAC) + f, a linear 2^f approximation.
//     sigma = k > 14-FRAC ? 16'h7FFF : k < -FRAC ? 0 :
//             k >= 0 ? s<<k : s>>(-k).
//   MUL (edge 4): prod = (sigma*eps)>>>FRAC, 32-bit signed, then saturated to
//     16 bits.
//   ADD (edge 5): z_out <= sat16(mu + prod); z_valid=1 for one cycle; state
//     returns to IDLE.
//   Latency: start sampled at edge 1, z_valid high after edge 5, i.e. 5 cycles.
//   busy is high after edges 1 through 4 and low from edge 5.
//   A new start is accepted in the same cycle z_valid is high. Back-to-back
//     throughput is one sample per 5 cycles.
//   Saturation clamps to +32767 and -32768. All shifts are arithmetic, floor
//     rounding; there is no wrap anywhere.
//   mu_in, logvar_in and eps_ext are sampled only on the accept edge; later
//     changes have no effect on an in-flight sample.
// TESTING
//   1. eps_sel=1, mu=0x0100, logvar=0, eps_ext=0x0080, start -> 5 cycles later
//      z_valid=1, z_out=0x0180.
//   2. eps_sel=1, mu=0, logvar=0x0200, eps_ext=0x0100 -> k=1, f=113, sigma=738,
//      z_out=0x02E2.
//   3. Saturation: mu=0x7F00, logvar=0x0E00, eps_ext=0x00FF -> sigma=0x7FFF,
//      z_out=0x7FFF.
//      Underflow: logvar=0x8000, mu=0x1234 -> sigma=0, z_out=0x1234.
//   4. LFSR: eps_sel=0 after reset, two samples with logvar=0, mu=0 ->
//      z_out=0x00E1 (eps=225), then 0xFFC3 (eps=-61, lfsr=0x59C3).
//   5. start pulsed during EXP/SIG/MUL -> ignored: one z_valid only, LFSR
//      advanced once.
//      start held high -> samples every 5 cycles.
//   6. rst deasserted->asserted during MUL -> z_out=0, z_valid never pulses,
//      busy=0, lfsr=SEED. The next sample after release behaves like scenario 4.

Source files
------------

// File: rtl/latent_reparam.sv
// Reparameterisation sampler: z = mu + exp(logvar/2) * eps in Q(16-FRAC).FRAC.
// Five-state FSM, one sample per accepted start; eps from an LFSR or an external value.
module latent_reparam #(
  parameter int                 FRAC  = 8,
  parameter logic signed [15:0] LOG2E = 16'sd369,
  parameter logic [15:0]        SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] mu_in,
  input  logic signed [15:0] logvar_in,
  input  logic               eps_sel,
  input  logic signed [15:0] eps_ext,
  output logic signed [15:0] z_out,
  output logic               z_valid,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, EXP, SIG, MUL, ADD} state_t;

  typedef struct packed {
    logic signed [15:0] mu;
    logic signed [15:0] logvar;
    logic signed [15:0] eps;
  } req_t;

  state_t             state;
  req_t               req;
  logic [15:0]        lfsr;
  logic signed [15:0] k;
  logic [FRAC-1:0]    f;
  logic signed [15:0] sigma;
  logic signed [15:0] prod;

  logic [15:0]        lfsr_nxt;
  logic signed [15:0] lfsr_eps;
  logic signed [31:0] y32, t32, prod32, sum32;
  logic signed [31:0] sig32, eps32;
  logic [15:0]        s, nk;
  logic signed [15:0] sigma_nxt;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // Nine LFSR bits reinterpreted as signed give eps in [-1,1) at FRAC=8.
  assign lfsr_eps = {{7{lfsr[8]}}, lfsr[8:0]};

  always_comb begin
    y32    = 32'(req.logvar) >>> 1;
    t32    = (y32 * 32'(LOG2E)) >>> FRAC;
    sig32  = 32'(sigma);
    eps32  = 32'(req.eps);
    prod32 = (sig32 * eps32) >>> FRAC;
    sum32  = 32'(req.mu) + 32'(prod);
  end

  // 2^(k+f) with 2^f approximated linearly as 1+f; clamped at both ends.
  always_comb begin
    s  = 16'(1 << FRAC) + {{(16-FRAC){1'b0}}, f};
    nk = 16'(-k);
    if (int'(k) > 14 - FRAC)   sigma_nxt = 16'sh7FFF;
    else if (int'(k) < -FRAC)  sigma_nxt = 16'sh0000;
    else if (k >= 16'sd0)      sigma_nxt = s << k[3:0];
    else                       sigma_nxt = s >> nk[3:0];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      req     <= '0;
      lfsr    <= SEED;
      k       <= '0;
      f       <= '0;
      sigma   <= '0;
      prod    <= '0;
      z_out   <= '0;
      z_valid <= 1'b0;
    end else begin
      z_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          req.mu     <= mu_in;
          req.logvar <= logvar_in;
          req.eps    <= eps_sel ? eps_ext : lfsr_eps;
          lfsr       <= lfsr_nxt;
          state      <= EXP;
        end
        EXP: begin
          k     <= 16'(t32 >>> FRAC);
          f     <= t32[FRAC-1:0];
          state <= SIG;
        end
        SIG: begin
          sigma <= sigma_nxt;
          state <= MUL;
        end
        MUL: begin
          prod  <= sat16(prod32);
          state <= ADD;
        end
        ADD: begin
          z_out   <= sat16(sum32);
          z_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latent_reparam.sv
// Bench for latent_reparam: directed spec vectors plus random samples against an
// integer-arithmetic reference of z = mu + 2^(logvar*log2e/2) * eps.
module tb_latent_reparam;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] mu_in = '0;
  logic signed [15:0] logvar_in = '0;
  logic               eps_sel = 1'b0;
  logic signed [15:0] eps_ext = '0;
  logic signed [15:0] z_out;
  logic               z_valid;
  logic               busy;

  int checks = 0;
  int passes = 0;
  int m_lfsr = 16'hACE1;

  latent_reparam dut (
    .clk(clk), .rst(rst), .start(start), .mu_in(mu_in), .logvar_in(logvar_in),
    .eps_sel(eps_sel), .eps_ext(eps_ext), .z_out(z_out), .z_valid(z_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(int a, int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int lfsr_step(int l);
    int fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l * 2) & 16'hFFFF) | fb;
  endfunction

  function automatic int lfsr_eps(int l);
    int v = l & 9'h1FF;
    return (v >= 256) ? v - 512 : v;
  endfunction

  // exp(logvar/2) = 2^(logvar/2 * log2 e); exponent split into integer k and fraction f/256.
  function automatic logic [15:0] model_z(int mu, int lv, int eps);
    int t, k, f, sigma, p;
    t = floor_div(floor_div(lv, 2) * 369, 256);
    k = floor_div(t, 256);
    f = t - k * 256;
    if (k > 6)       sigma = 32767;
    else if (k < -8) sigma = 0;
    else if (k >= 0) sigma = (256 + f) * (1 << k);
    else             sigma = (256 + f) / (1 << (-k));
    p = clamp16(floor_div(sigma * eps, 256));
    return 16'(clamp16(mu + p));
  endfunction

  // Drives one sample, scrambles inputs after accept, reports latency and busy snapshots.
  task automatic do_sample(input logic signed [15:0] mu, input logic signed [15:0] lv,
                           input logic signed [15:0] e, input logic sel,
                           output logic [15:0] z, output logic [15:0] zexp,
                           output int lat, output logic busy1, output logic busyv);
    zexp = model_z(int'(mu), int'(lv), sel ? int'(e) : lfsr_eps(m_lfsr));
    m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk); #1;
    mu_in = mu; logvar_in = lv; eps_ext = e; eps_sel = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mu_in = 16'($urandom); logvar_in = 16'($urandom); eps_ext = 16'($urandom);
    eps_sel = ~sel;
    busy1 = busy;
    lat = 1;
    while (!z_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    z = z_out;
    busyv = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (z_out !== 16'h0 || z_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_state: z_out=%h z_valid=%b busy=%b, want 0/0/0", z_out, z_valid, busy);
    else passes++;
    rst = 1'b1;
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_lfsr();
    logic [15:0] z, ze; int lat; logic b1, bv;
    do_sample(16'sh0, 16'sh0, 16'sh0, 1'b0, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'h00E1 || ze !== 16'h00E1) $display("FAIL lfsr_first: z=%h model=%h want 00e1", z, ze);
    else passes++;
    do_sample(16'sh0, 16'sh0, 16'sh0, 1'b0, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'hFFC3) $display("FAIL lfsr_second: z=%h want ffc3", z);
    else passes++;
  endtask

  task automatic test_directed();
    logic [15:0] z, ze; int lat; logic b1, bv;
    do_sample(16'sh0100, 16'sh0, 16'sh0080, 1'b1, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'h0180) $display("FAIL dir_basic: z=%h want 0180", z);
    else passes++;
    checks++;
    if (lat !== 5 || b1 !== 1'b1 || bv !== 1'b0)
      $display("FAIL dir_latency: lat=%0d busy1=%b busyv=%b want 5/1/0", lat, b1, bv);
    else passes++;
    do_sample(16'sh0, 16'sh0200, 16'sh0100, 1'b1, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'h02E2) $display("FAIL dir_exp: z=%h want 02e2", z);
    else passes++;
    do_sample(16'sh7F00, 16'sh0E00, 16'sh00FF, 1'b1, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'h7FFF) $display("FAIL dir_sat: z=%h want 7fff", z);
    else passes++;
    do_sample(16'sh1234, 16'sh8000, 16'sh00FF, 1'b1, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'h1234) $display("FAIL dir_underflow: z=%h want 1234", z);
    else passes++;
    do_sample(-16'sh7F00, 16'sh0E00, -16'sh0100, 1'b1, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'h8000) $display("FAIL dir_negsat: z=%h want 8000", z);
    else passes++;
  endtask

  task automatic test_random();
    logic [15:0] z, ze; int lat; logic b1, bv;
    for (int i = 0; i < 24; i++) begin
      do_sample(16'($urandom), 16'($urandom_range(0, 65535)), 16'($urandom),
                1'($urandom), z, ze, lat, b1, bv);
      checks++;
      if (z !== ze || lat !== 5) $display("FAIL random_%0d: z=%h lat=%0d want %h lat 5", i, z, lat, ze);
      else passes++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] ze, z, ze2; int nv = 0; int lat; logic b1, bv;
    ze = model_z(0, 0, lfsr_eps(m_lfsr));
    m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk); #1;
    mu_in = 16'sh0; logvar_in = 16'sh0; eps_sel = 1'b0; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 5) start = 1'b0;
      if (z_valid) begin nv++; z = z_out; end
    end
    checks++;
    if (nv !== 1 || z !== ze) $display("FAIL busy_ignore: pulses=%0d z=%h want 1 pulse z=%h", nv, z, ze);
    else passes++;
    do_sample(16'sh0, 16'sh0, 16'sh0, 1'b0, z, ze2, lat, b1, bv);
    checks++;
    if (z !== ze2) $display("FAIL busy_lfsr_once: z=%h want %h", z, ze2);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int at[$];
    logic [15:0] ze, zs[$];
    ze = model_z(16'sh0100, 16'sh0200, 16'sh0040);
    @(posedge clk); #1;
    mu_in = 16'sh0100; logvar_in = 16'sh0200; eps_ext = 16'sh0040; eps_sel = 1'b1; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 15) start = 1'b0;
      if (z_valid) begin at.push_back(c); zs.push_back(z_out); end
    end
    for (int i = 0; i < 3; i++) m_lfsr = lfsr_step(m_lfsr);
    checks++;
    if (at.size() != 3 || at[0] != 5 || at[1] != 10 || at[2] != 15)
      $display("FAIL b2b_timing: pulses=%0d first=%0d want 3 at 5,10,15", at.size(), (at.size() > 0) ? at[0] : -1);
    else passes++;
    checks++;
    if (zs.size() != 3 || zs[0] !== ze || zs[2] !== ze)
      $display("FAIL b2b_value: z=%h want %h", (zs.size() > 0) ? zs[0] : 16'hx, ze);
    else passes++;
  endtask

  task automatic test_reset_abort();
    int nv = 0; logic [15:0] z, ze; int lat; logic b1, bv;
    @(posedge clk); #1;
    mu_in = 16'sh0500; logvar_in = 16'sh0; eps_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (z_out !== 16'h0 || busy !== 1'b0 || z_valid !== 1'b0)
      $display("FAIL abort_state: z_out=%h busy=%b z_valid=%b want 0/0/0", z_out, busy, z_valid);
    else passes++;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst = 1'b1;
      if (z_valid) nv++;
    end
    checks++;
    if (nv !== 0) $display("FAIL abort_no_valid: pulses=%0d want 0", nv);
    else passes++;
    m_lfsr = 16'hACE1;
    do_sample(16'sh0, 16'sh0, 16'sh0, 1'b0, z, ze, lat, b1, bv);
    checks++;
    if (z !== 16'h00E1) $display("FAIL abort_lfsr_seed: z=%h want 00e1", z);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
